// File: rtl/spi_cmd_bridge.sv
// Byte-level SPI command decoder: register file access, screen-reset control and pixel-word streaming.
// Optional feature: define SPI_CMD_BURST_EN for auto-incrementing burst writes.
module spi_cmd_bridge #(
    parameter int NREG      = 8,
    parameter int PIX_BYTES = 6
) (
    input  logic                   clk_p,
    input  logic                   rst_p,
    input  logic                   cs_act,
    input  logic                   byte_vld,
    input  logic [7:0]             byte_i,
    input  logic [7:0]             stream_ret,
    output logic [7:0]             tx_byte,
    output logic [8*NREG-1:0]      reg_flat,
    output logic [8*PIX_BYTES-1:0] pix_data,
    output logic                   pix_vld,
    output logic                   stream_on,
    output logic                   screen_rst,
    output logic                   cmd_err
);

    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(PIX_BYTES + 1);
    localparam int PW = 8 * PIX_BYTES;

    localparam logic [8:0]    NREG_W    = 9'(NREG);
    localparam logic [7:0]    LAST_ADDR = 8'(NREG - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PIX_BYTES - 1);

    localparam logic [7:0] OP_WR      = 8'h80;
    localparam logic [7:0] OP_RD      = 8'h81;
    localparam logic [7:0] OP_STREAM  = 8'h55;
    localparam logic [7:0] OP_SCR_CLR = 8'h40;
    localparam logic [7:0] OP_SCR_SET = 8'h41;

    typedef enum logic [2:0] {
        S_OP,
        S_ARG,
        S_WDAT,
        S_STREAM,
        S_DROP
    } state_e;

    state_e        state_q, state_d;
    logic          rd_q, rd_d;
    logic [7:0]    addr_q, addr_d;
    logic          wr_ok_q, wr_ok_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] asm_q, asm_d;
    logic [PW-1:0] pix_data_q, pix_data_d;
    logic          pix_vld_q, pix_vld_d;
    logic [7:0]    tx_q, tx_d;
    logic          screen_rst_q, screen_rst_d;
    logic          cmd_err_q, cmd_err_d;
    logic [7:0]    regs_q [NREG];
    logic [7:0]    regs_d [NREG];

    logic [PW-1:0] asm_shift;
    logic          addr_ok;

    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        addr_d       = addr_q;
        wr_ok_d      = wr_ok_q;
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        pix_data_d   = pix_data_q;
        pix_vld_d    = 1'b0;
        tx_d         = tx_q;
        screen_rst_d = screen_rst_q;
        cmd_err_d    = 1'b0;
        regs_d       = regs_q;

        // First received byte ends up in the MSBs once the word is complete.
        asm_shift      = asm_q << 8;
        asm_shift[7:0] = byte_i;
        addr_ok        = ({1'b0, byte_i} < NREG_W);

        if (!cs_act) begin
            // Abort wins over a coincident byte strobe.
            state_d = S_OP;
            cnt_d   = '0;
            asm_d   = '0;
            tx_d    = 8'hFF;
        end else if (byte_vld) begin
            tx_d = 8'hFF;
            case (state_q)
                S_OP: begin
                    case (byte_i)
                        OP_WR, OP_RD: begin
                            rd_d    = (byte_i == OP_RD);
                            state_d = S_ARG;
                        end
                        OP_STREAM: begin
                            cnt_d   = '0;
                            asm_d   = '0;
                            state_d = S_STREAM;
                        end
                        OP_SCR_CLR: begin
                            screen_rst_d = 1'b0;
                            state_d      = S_DROP;
                        end
                        OP_SCR_SET: begin
                            screen_rst_d = 1'b1;
                            state_d      = S_DROP;
                        end
                        default: begin
                            cmd_err_d = 1'b1;
                            state_d   = S_DROP;
                        end
                    endcase
                end
                S_ARG: begin
                    if (rd_q) begin
                        tx_d    = addr_ok ? regs_q[byte_i[AW-1:0]] : 8'h00;
                        state_d = S_DROP;
                    end else begin
                        addr_d  = byte_i;
                        wr_ok_d = addr_ok;
                        state_d = S_WDAT;
                    end
                end
                S_WDAT: begin
                    if (wr_ok_q) begin
                        regs_d[addr_q[AW-1:0]] = byte_i;
                    end
`ifdef SPI_CMD_BURST_EN
                    addr_d = (addr_q == LAST_ADDR) ? 8'h00 : addr_q + 8'd1;
`else
                    state_d = S_DROP;
`endif
                end
                S_STREAM: begin
                    tx_d  = stream_ret;
                    asm_d = asm_shift;
                    if (cnt_q == CNT_LAST) begin
                        pix_data_d = asm_shift;
                        pix_vld_d  = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            state_q      <= S_OP;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            wr_ok_q      <= 1'b0;
            cnt_q        <= '0;
            asm_q        <= '0;
            pix_data_q   <= '0;
            pix_vld_q    <= 1'b0;
            tx_q         <= 8'hFF;
            screen_rst_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
            wr_ok_q      <= wr_ok_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            pix_data_q   <= pix_data_d;
            pix_vld_q    <= pix_vld_d;
            tx_q         <= tx_d;
            screen_rst_q <= screen_rst_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    // NOTE: the register file is visible on reg_flat, so it is reset as flops rather than left as RAM.
    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign reg_flat[8*g +: 8] = regs_q[g];
    end

    assign tx_byte    = tx_q;
    assign pix_data   = pix_data_q;
    assign pix_vld    = pix_vld_q;
    assign stream_on  = (state_q == S_STREAM);
    assign screen_rst = screen_rst_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Directed testbench for spi_cmd_bridge (NREG=8, PIX_BYTES=6); burst expectations follow SPI_CMD_BURST_EN.
module tb_spi_cmd_bridge;

    logic        clk_p = 1'b0;
    logic        rst_p;
    logic        cs_act;
    logic        byte_vld;
    logic [7:0]  byte_i;
    logic [7:0]  stream_ret;
    logic [7:0]  tx_byte;
    logic [63:0] reg_flat;
    logic [47:0] pix_data;
    logic        pix_vld;
    logic        stream_on;
    logic        screen_rst;
    logic        cmd_err;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_flat = '0;

    spi_cmd_bridge #(.NREG(8), .PIX_BYTES(6)) dut (
        .clk_p      (clk_p),
        .rst_p      (rst_p),
        .cs_act     (cs_act),
        .byte_vld   (byte_vld),
        .byte_i     (byte_i),
        .stream_ret (stream_ret),
        .tx_byte    (tx_byte),
        .reg_flat   (reg_flat),
        .pix_data   (pix_data),
        .pix_vld    (pix_vld),
        .stream_on  (stream_on),
        .screen_rst (screen_rst),
        .cmd_err    (cmd_err)
    );

    always #5 clk_p = ~clk_p;

    // Strobe one byte; returns at the falling edge after the sampling edge, when outputs are settled.
    task automatic send(input logic [7:0] b);
        @(negedge clk_p);
        byte_i   = b;
        byte_vld = 1'b1;
        @(negedge clk_p);
        byte_vld = 1'b0;
    endtask

    task automatic cs_cycle();
        @(negedge clk_p);
        cs_act = 1'b0;
        @(negedge clk_p);
        cs_act = 1'b1;
    endtask

    task automatic test_reset();
        rst_p = 1'b1; cs_act = 1'b0; byte_vld = 1'b0; byte_i = 8'h00; stream_ret = 8'hA5;
        repeat (3) @(negedge clk_p);
        checks++; if (tx_byte !== 8'hFF) begin errors++; $display("FAIL reset_tx got %h exp ff", tx_byte); end
        checks++; if (reg_flat !== 64'h0) begin errors++; $display("FAIL reset_regs got %h exp 0", reg_flat); end
        checks++; if (pix_data !== 48'h0) begin errors++; $display("FAIL reset_pix got %h exp 0", pix_data); end
        checks++; if ({pix_vld, stream_on, screen_rst, cmd_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {pix_vld, stream_on, screen_rst, cmd_err});
        end
        rst_p = 1'b0;
        @(negedge clk_p);
        cs_act = 1'b1;
    endtask

    task automatic test_write_read();
        send(8'h80);
        checks++; if (tx_byte !== 8'hFF) begin errors++; $display("FAIL wr_op_tx got %h exp ff", tx_byte); end
        send(8'h02);
        send(8'h5A);
        exp_flat[23:16] = 8'h5A;
        checks++; if (reg_flat !== exp_flat) begin errors++; $display("FAIL wr_reg2 got %h exp %h", reg_flat, exp_flat); end
        checks++; if (tx_byte !== 8'hFF) begin errors++; $display("FAIL wr_data_tx got %h exp ff", tx_byte); end
        cs_cycle();
        send(8'h81);
        send(8'h02);
        checks++; if (tx_byte !== 8'h5A) begin errors++; $display("FAIL rd_reg2_tx got %h exp 5a", tx_byte); end
        send(8'h00);
        checks++; if (tx_byte !== 8'hFF) begin errors++; $display("FAIL rd_after_tx got %h exp ff", tx_byte); end
    endtask

    task automatic test_out_of_range();
        cs_cycle(); send(8'h80); send(8'h09); send(8'h33);
        checks++; if (reg_flat !== exp_flat) begin errors++; $display("FAIL oor_write got %h exp %h", reg_flat, exp_flat); end
        cs_cycle(); send(8'h81); send(8'h09);
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL oor_read9 got %h exp 00", tx_byte); end
        cs_cycle(); send(8'h81); send(8'h08);
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL oor_read8 got %h exp 00", tx_byte); end
        cs_cycle(); send(8'h80); send(8'h07); send(8'hC3);
        exp_flat[63:56] = 8'hC3;
        checks++; if (reg_flat !== exp_flat) begin errors++; $display("FAIL wr_reg7 got %h exp %h", reg_flat, exp_flat); end
        cs_cycle(); send(8'h81); send(8'h07);
        checks++; if (tx_byte !== 8'hC3) begin errors++; $display("FAIL rd_reg7 got %h exp c3", tx_byte); end
    endtask

    task automatic test_stream();
        logic exp_vld;
        stream_ret = 8'hA5;
        cs_cycle(); send(8'h55);
        checks++; if (stream_on !== 1'b1) begin errors++; $display("FAIL stream_on got %b exp 1", stream_on); end
        checks++; if (tx_byte !== 8'hFF) begin errors++; $display("FAIL stream_op_tx got %h exp ff", tx_byte); end
        for (int i = 1; i <= 12; i++) begin
            send(8'(i));
            exp_vld = (i % 6 == 0);
            checks++; if (pix_vld !== exp_vld) begin errors++; $display("FAIL stream_vld_%0d got %b exp %b", i, pix_vld, exp_vld); end
            checks++; if (tx_byte !== 8'hA5) begin errors++; $display("FAIL stream_tx_%0d got %h exp a5", i, tx_byte); end
            if (i == 6) begin
                checks++; if (pix_data !== 48'h010203040506) begin errors++; $display("FAIL stream_word1 got %h exp 010203040506", pix_data); end
            end
            if (i == 12) begin
                checks++; if (pix_data !== 48'h0708090A0B0C) begin errors++; $display("FAIL stream_word2 got %h exp 0708090a0b0c", pix_data); end
            end
        end
        cs_cycle();
        checks++; if (stream_on !== 1'b0) begin errors++; $display("FAIL stream_off got %b exp 0", stream_on); end
        checks++; if (tx_byte !== 8'hFF) begin errors++; $display("FAIL stream_abort_tx got %h exp ff", tx_byte); end
        checks++; if (pix_data !== 48'h0708090A0B0C) begin errors++; $display("FAIL stream_hold got %h exp 0708090a0b0c", pix_data); end
    endtask

    task automatic test_abort();
        int pulses = 0;
        send(8'h55);
        for (int i = 0; i < 4; i++) begin
            send(8'hE1 + 8'(i));
            if (pix_vld === 1'b1) pulses++;
        end
        cs_cycle(); send(8'h55);
        for (int i = 0; i < 6; i++) begin
            send(8'h11 + 8'(i));
            if (pix_vld === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL abort_pulses got %0d exp 1", pulses); end
        checks++; if (pix_data !== 48'h111213141516) begin errors++; $display("FAIL abort_word got %h exp 111213141516", pix_data); end
        // Byte coincident with cs_act low must be discarded.
        cs_cycle();
        @(negedge clk_p);
        cs_act = 1'b0; byte_vld = 1'b1; byte_i = 8'h41;
        @(negedge clk_p);
        cs_act = 1'b1; byte_vld = 1'b0;
        checks++; if (screen_rst !== 1'b0) begin errors++; $display("FAIL abort_same_cycle got %b exp 0", screen_rst); end
        send(8'h81); send(8'h02);
        checks++; if (tx_byte !== 8'h5A) begin errors++; $display("FAIL abort_then_read got %h exp 5a", tx_byte); end
    endtask

    task automatic test_ctrl_err();
        int pulses = 0;
        cs_cycle(); send(8'h41);
        checks++; if (screen_rst !== 1'b1) begin errors++; $display("FAIL scr_set got %b exp 1", screen_rst); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL scr_set_err got %b exp 0", cmd_err); end
        send(8'h80); send(8'h00); send(8'h99);
        checks++; if (reg_flat !== exp_flat) begin errors++; $display("FAIL drop_ignored got %h exp %h", reg_flat, exp_flat); end
        cs_cycle();
        checks++; if (screen_rst !== 1'b1) begin errors++; $display("FAIL scr_retain got %b exp 1", screen_rst); end
        send(8'h40);
        checks++; if (screen_rst !== 1'b0) begin errors++; $display("FAIL scr_clr got %b exp 0", screen_rst); end
        cs_cycle(); send(8'h77);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", cmd_err); end
        @(negedge clk_p);
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b exp 0", cmd_err); end
        send(8'h55);
        for (int i = 0; i < 6; i++) begin
            send(8'h20 + 8'(i));
            if (pix_vld === 1'b1 || stream_on === 1'b1 || cmd_err === 1'b1) pulses++;
        end
        send(8'h41);
        checks++; if (pulses != 0) begin errors++; $display("FAIL err_drop_activity got %0d exp 0", pulses); end
        checks++; if (screen_rst !== 1'b0) begin errors++; $display("FAIL err_drop_scr got %b exp 0", screen_rst); end
    endtask

    task automatic test_burst();
        cs_cycle(); send(8'h80); send(8'h06); send(8'hA0); send(8'hA1); send(8'hA2);
        exp_flat[55:48] = 8'hA0;
`ifdef SPI_CMD_BURST_EN
        exp_flat[63:56] = 8'hA1;
        exp_flat[7:0]   = 8'hA2;
`endif
        checks++; if (reg_flat !== exp_flat) begin errors++; $display("FAIL burst_regs got %h exp %h", reg_flat, exp_flat); end
        checks++; if (tx_byte !== 8'hFF) begin errors++; $display("FAIL burst_tx got %h exp ff", tx_byte); end
    endtask

    task automatic test_reset_mid();
        cs_cycle(); send(8'h41);
        cs_cycle(); send(8'h55); send(8'h01); send(8'h02);
        @(negedge clk_p);
        rst_p = 1'b1;
        #1;
        checks++; if (reg_flat !== 64'h0) begin errors++; $display("FAIL rst_mid_regs got %h exp 0", reg_flat); end
        checks++; if ({stream_on, screen_rst, tx_byte} !== {2'b00, 8'hFF}) begin
            errors++; $display("FAIL rst_mid_out got %b%b %h exp 00 ff", stream_on, screen_rst, tx_byte);
        end
        checks++; if (pix_data !== 48'h0) begin errors++; $display("FAIL rst_mid_pix got %h exp 0", pix_data); end
        @(negedge clk_p);
        rst_p = 1'b0;
        cs_cycle(); send(8'h81); send(8'h02);
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL rst_mid_read got %h exp 00", tx_byte); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_stream();
        test_abort();
        test_ctrl_err();
        test_burst();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
